// File: rtl/rsa_pkg.sv
// Shared definitions for the RSA key-setup control path: default operand
// width, first candidate exponent and the exponent-search state encoding.
package rsa_pkg;

    localparam int RSA_WIDTH   = 12;
    localparam int RSA_E_START = 3;

    typedef enum logic [2:0] {
        IDLE,
        CHECKRANGE,
        ARM,
        RUN,
        EVAL,
        FINISH
    } state_t;

endpackage

// File: rtl/exponent_search_ctrl.sv
// Exponent search sequencer: walks odd candidates e = E_START, E_START+2, ...
// through the shared GCD datapath until gcd(e, phi) = 1, the candidate
// reaches phi, the candidate wraps, or a GCD run exceeds TIMEOUT cycles.
module exponent_search_ctrl
    import rsa_pkg::*;
#(
    parameter int WIDTH   = RSA_WIDTH,
    parameter int E_START = RSA_E_START,
    parameter int TIMEOUT = 4096
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] phi,
    output logic             busy,
    output logic             done,
    output logic             found,
    output logic             timeout,
    output logic [WIDTH-1:0] e_out,
    output logic [WIDTH-1:0] gcd_a,
    output logic [WIDTH-1:0] gcd_b,
    output logic             gcd_flag,
    input  logic [WIDTH-1:0] gcd_result,
    input  logic             gcd_complete
);

    // Counter is one bit wider than needed so TIMEOUT-1 always fits.
    localparam int CW = $clog2(TIMEOUT) + 1;
    localparam logic [CW-1:0]    CNT_LAST   = CW'(TIMEOUT - 1);
    localparam logic [WIDTH-1:0] CAND_FIRST = WIDTH'(E_START);
    localparam logic [WIDTH-1:0] ONE        = WIDTH'(1);

    state_t           state_reg;
    logic [WIDTH-1:0] cand_reg;
    logic [WIDTH-1:0] res_reg;
    logic [CW-1:0]    cnt_reg;
    logic             busy_reg;
    logic             done_reg;
    logic             found_reg;
    logic             timeout_reg;
    logic [WIDTH-1:0] e_out_reg;
    logic [WIDTH-1:0] gcd_a_reg;
    logic [WIDTH-1:0] gcd_b_reg;
    logic             gcd_flag_reg;

    // Next candidate in WIDTH+1 bits; the top bit flags a wrap past 2^WIDTH.
    logic [WIDTH:0] cand_next;
    assign cand_next = {1'b0, cand_reg} + (WIDTH + 1)'(2);

    assign busy     = busy_reg;
    assign done     = done_reg;
    assign found    = found_reg;
    assign timeout  = timeout_reg;
    assign e_out    = e_out_reg;
    assign gcd_a    = gcd_a_reg;
    assign gcd_b    = gcd_b_reg;
    assign gcd_flag = gcd_flag_reg;

    // Search FSM; every output is a register. done is raised on the edge that
    // enters FINISH, so it is high exactly while the FSM sits in FINISH and a
    // start arriving in that cycle is not seen by IDLE.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= IDLE;
            cand_reg     <= '0;
            res_reg      <= '0;
            cnt_reg      <= '0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            found_reg    <= 1'b0;
            timeout_reg  <= 1'b0;
            e_out_reg    <= '0;
            gcd_a_reg    <= '0;
            gcd_b_reg    <= '0;
            gcd_flag_reg <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            unique case (state_reg)
                IDLE: begin
                    if (start) begin
                        gcd_b_reg   <= phi;
                        cand_reg    <= CAND_FIRST;
                        found_reg   <= 1'b0;
                        timeout_reg <= 1'b0;
                        e_out_reg   <= '0;
                        busy_reg    <= 1'b1;
                        state_reg   <= CHECKRANGE;
                    end
                end
                CHECKRANGE: begin
                    if (cand_reg >= gcd_b_reg) begin
                        done_reg  <= 1'b1;
                        state_reg <= FINISH;
                    end else begin
                        gcd_a_reg    <= cand_reg;
                        gcd_flag_reg <= 1'b0;
                        state_reg    <= ARM;
                    end
                end
                ARM: begin
                    // One low cycle on the flag has cleared the GCD; start it now.
                    gcd_flag_reg <= 1'b1;
                    cnt_reg      <= '0;
                    state_reg    <= RUN;
                end
                RUN: begin
                    if (gcd_complete) begin
                        res_reg   <= gcd_result;
                        state_reg <= EVAL;
                    end else if (cnt_reg == CNT_LAST) begin
                        timeout_reg  <= 1'b1;
                        found_reg    <= 1'b0;
                        gcd_flag_reg <= 1'b0;
                        done_reg     <= 1'b1;
                        state_reg    <= FINISH;
                    end else begin
                        cnt_reg <= cnt_reg + CW'(1);
                    end
                end
                EVAL: begin
                    gcd_flag_reg <= 1'b0;
                    if (res_reg == ONE) begin
                        e_out_reg <= cand_reg;
                        found_reg <= 1'b1;
                        done_reg  <= 1'b1;
                        state_reg <= FINISH;
                    end else if (cand_next[WIDTH]) begin
                        // A zero result (only from a zero operand) also lands
                        // here or in the advance branch: not coprime.
                        done_reg  <= 1'b1;
                        state_reg <= FINISH;
                    end else begin
                        cand_reg  <= cand_next[WIDTH-1:0];
                        state_reg <= CHECKRANGE;
                    end
                end
                FINISH: begin
                    busy_reg     <= 1'b0;
                    gcd_flag_reg <= 1'b0;
                    state_reg    <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_exponent_search_ctrl.sv
// Bench for exponent_search_ctrl: a behavioural GCD unit with programmable
// per-run latency sits beside the DUT, and a search-level model predicts the
// candidate sequence, the outcome and the exact cycle of the done pulse.
module tb_exponent_search_ctrl;

    localparam int W      = 12;
    localparam int TMO    = 16;
    localparam int NSLOTS = 16384;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [W-1:0] phi;
    logic         busy, done, found, timeout;
    logic [W-1:0] e_out, gcd_a, gcd_b;
    logic         gcd_flag;
    logic [W-1:0] gcd_result = '0;
    logic         gcd_complete = 1'b0;

    int checks = 0;
    int errors = 0;

    exponent_search_ctrl #(.WIDTH(W), .E_START(3), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset), .start(start), .phi(phi),
        .busy(busy), .done(done), .found(found), .timeout(timeout),
        .e_out(e_out), .gcd_a(gcd_a), .gcd_b(gcd_b), .gcd_flag(gcd_flag),
        .gcd_result(gcd_result), .gcd_complete(gcd_complete)
    );

    always #5 clk = ~clk;

    function automatic int ref_gcd(input int x, input int y);
        int a, b, t;
        a = x;
        b = y;
        while (b != 0) begin
            t = a % b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    // Behavioural GCD unit: complete rises lat cycles after the flag goes high
    // and stays up while the flag holds; each rising flag starts a new run.
    int lat_arr [NSLOTS];
    int seen_a  [NSLOTS];
    int seen_b  [NSLOTS];
    int runs   = 0;
    int g_cnt  = 0;
    logic flag_d = 1'b0;
    int lat_now;

    always_comb begin
        lat_now = 1;
        if (flag_d) lat_now = lat_arr[(runs > 0) ? runs - 1 : 0];
        else        lat_now = lat_arr[runs];
    end

    always @(posedge clk) begin
        flag_d <= gcd_flag;
        if (!gcd_flag) begin
            g_cnt        <= 0;
            gcd_complete <= 1'b0;
        end else begin
            g_cnt <= g_cnt + 1;
            if (!flag_d) begin
                seen_a[runs] <= int'(gcd_a);
                seen_b[runs] <= int'(gcd_b);
                runs         <= runs + 1;
            end
            if (g_cnt == lat_now - 1) begin
                gcd_complete <= 1'b1;
                gcd_result   <= W'(ref_gcd(int'(gcd_a), int'(gcd_b)));
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Search-level model: odd candidates from 3; each tried candidate costs
    // check+arm (2 cycles), lat+1 run cycles and one evaluate cycle.
    int m_cand [256];

    task automatic model(input int phi_v, input int base, output int n,
                         output int fnd, output int tmo, output int e, output int nr);
        int cand, lat, g;
        cand = 3; n = 0; fnd = 0; tmo = 0; e = 0; nr = 0;
        forever begin
            if (cand >= phi_v) begin
                n += 1;
                break;
            end
            if (nr < 256) m_cand[nr] = cand;
            lat = lat_arr[base + nr];
            n  += 2;
            nr += 1;
            if (lat >= TMO) begin
                n  += TMO;
                tmo = 1;
                break;
            end
            n += lat + 2;
            g  = ref_gcd(cand, phi_v);
            if (g == 1) begin
                fnd = 1;
                e   = cand;
                break;
            end
            cand += 2;
            if (cand >= (1 << W)) break;
        end
    endtask

    // mode 0: random short latencies, 1: fixed value, 2: mixed with timeouts
    task automatic set_lat(input int mode, input int val);
        for (int i = 0; i < 256; i++) begin
            if (runs + i < NSLOTS) begin
                if (mode == 1)      lat_arr[runs + i] = val;
                else if (mode == 0) lat_arr[runs + i] = $urandom_range(1, 12);
                else lat_arr[runs + i] = ($urandom_range(0, 9) == 0) ?
                                         $urandom_range(16, 20) : $urandom_range(1, 15);
            end
        end
    endtask

    task automatic run_search(input int phi_v, input int poke_busy, input int poke_done,
                              output int o_n, output int o_fnd, output int o_tmo,
                              output int o_e, output int o_nr);
        int base, n, fnd, tmo, e, nr, got, rises;
        logic prev_flag;
        base = runs;
        model(phi_v, base, n, fnd, tmo, e, nr);
        o_n = n; o_fnd = fnd; o_tmo = tmo; o_e = e; o_nr = nr;
        phi   = W'(phi_v);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        phi   = W'($urandom);
        got = 0;
        rises = 0;
        prev_flag = gcd_flag;
        for (int k = 1; k <= 6000; k++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            if (gcd_flag && !prev_flag) rises++;
            prev_flag = gcd_flag;
            if (done) begin
                got = k;
                break;
            end
            chk("busy_while_running", int'(busy), 1);
            if (poke_busy != 0 && k == 3) begin
                start = 1'b1;
                phi   = 12'd3;
            end
        end
        chk("done_cycle", got, n);
        chk("busy_on_done", int'(busy), 1);
        chk("found", int'(found), fnd);
        chk("timeout", int'(timeout), tmo);
        chk("e_out", int'(e_out), e);
        chk("flag_rises", rises, nr);
        if (poke_done != 0) begin
            start = 1'b1;
            phi   = 12'd5;
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("busy_after_done", int'(busy), 0);
        chk("done_one_cycle", int'(done), 0);
        chk("e_out_hold", int'(e_out), e);
        chk("found_hold", int'(found), fnd);
        chk("gcd_runs", runs - base, nr);
        for (int i = 0; i < nr && i < 256; i++) begin
            chk("cand_seq", seen_a[base + i], m_cand[i]);
            chk("gcd_b_latched", seen_b[base + i], phi_v);
        end
        $display("search phi=%0d found=%0d timeout=%0d e_out=%0d runs=%0d done_at=%0d",
                 phi_v, found, timeout, e_out, runs - base, got);
    endtask

    initial begin
        int n, fnd, tmo, e, nr, pulses;
        reset = 1'b1;
        start = 1'b0;
        phi   = '0;
        for (int i = 0; i < NSLOTS; i++) lat_arr[i] = 1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_found", int'(found), 0);
        chk("rst_timeout", int'(timeout), 0);
        chk("rst_e_out", int'(e_out), 0);
        chk("rst_gcd_a", int'(gcd_a), 0);
        chk("rst_gcd_b", int'(gcd_b), 0);
        chk("rst_gcd_flag", int'(gcd_flag), 0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // phi = 60: 3 and 5 share factors, 7 is coprime
        set_lat(0, 0);
        run_search(60, 0, 0, n, fnd, tmo, e, nr);
        chk("lit60_e", e, 7);
        chk("lit60_runs", nr, 3);
        chk("lit60_found", fnd, 1);

        // phi = 3120 = 60 * 52
        set_lat(0, 0);
        run_search(3120, 0, 0, n, fnd, tmo, e, nr);
        chk("lit3120_e", e, 7);

        // phi below or equal to the first candidate
        run_search(3, 0, 0, n, fnd, tmo, e, nr);
        chk("lit3_n", n, 1);
        chk("lit3_runs", nr, 0);
        run_search(2, 0, 0, n, fnd, tmo, e, nr);
        chk("lit2_n", n, 1);

        // GCD that never completes
        set_lat(1, 100000);
        run_search(100, 0, 0, n, fnd, tmo, e, nr);
        chk("lit_tmo_n", n, 18);
        chk("lit_tmo_flag", tmo, 1);

        // completion on the last allowed cycle wins over the limit
        set_lat(1, TMO - 1);
        run_search(100, 0, 0, n, fnd, tmo, e, nr);
        chk("lit_edge_n", n, 19);
        chk("lit_edge_tmo", tmo, 0);
        chk("lit_edge_e", e, 3);

        // one cycle longer times out
        set_lat(1, TMO);
        run_search(100, 0, 0, n, fnd, tmo, e, nr);
        chk("lit_late_tmo", tmo, 1);

        // reset in the middle of a GCD run
        set_lat(1, 10);
        phi   = 12'd60;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("pre_reset_flag", int'(gcd_flag), 1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("reset_flag", int'(gcd_flag), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        pulses = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (done) pulses++;
        end
        chk("reset_no_done", pulses, 0);
        $display("reset mid-run: busy=%0d gcd_flag=%0d done_pulses=%0d", busy, gcd_flag, pulses);
        set_lat(0, 0);
        run_search(60, 0, 0, n, fnd, tmo, e, nr);
        chk("lit_after_reset_e", e, 7);

        // starts while busy and on the done cycle are ignored; the next one lands
        set_lat(0, 0);
        run_search(60, 1, 1, n, fnd, tmo, e, nr);
        chk("lit_poke_e", e, 7);
        set_lat(0, 0);
        run_search(60, 0, 0, n, fnd, tmo, e, nr);

        // random phi and GCD latencies, including occasional timeouts
        for (int t = 0; t < 25; t++) begin
            set_lat(2, 0);
            run_search(int'($urandom_range(0, 4095)), 0, 0, n, fnd, tmo, e, nr);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/exponent_search_ctrl.md
Name: exponent_search_ctrl

Overview:
- Sequencer that finds the RSA public exponent e for a given phi.
- Drives the shared 12-bit GCD datapath (a, b, flag in; gcd, complete out) through candidates e = E_START, E_START+2, … until gcd(e, phi) = 1.
- Sits between key-setup control and the GCD unit. It is the only master of the GCD operand and flag inputs.

Parameters:
- WIDTH, 12, operand width; matches the GCD datapath.
- E_START, 3, first candidate exponent; must be odd and ≥ 3.
- TIMEOUT, 4096, maximum cycles allowed per GCD run before abort.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a search; ignored while busy = 1.
- phi  in  WIDTH  totient value; sampled on the accepted start.
- busy  out  1  high from accepted start until the done pulse.
- done  out  1  one-cycle pulse when the search ends.
- found  out  1  valid with done; 1 = e_out is coprime to phi.
- timeout  out  1  valid with done; 1 = a GCD run exceeded TIMEOUT.
- e_out  out  WIDTH  found exponent; held until the next accepted start.
- gcd_a  out  WIDTH  GCD operand a (candidate e).
- gcd_b  out  WIDTH  GCD operand b (latched phi).
- gcd_flag  out  1  GCD enable. Low clears the unit; high runs it.
- gcd_result  in  WIDTH  GCD output.
- gcd_complete  in  1  GCD finished; stays high while gcd_flag stays high.

Behaviour:
- Reset values: busy = 0, done = 0, found = 0, timeout = 0, e_out = 0, gcd_a = 0, gcd_b = 0, gcd_flag = 0. State goes to IDLE.
- Reset has priority over every other event. Asserting it mid-run drops gcd_flag in the same edge and produces no done pulse.
- IDLE, on start:
  - latch phi into gcd_b;
  - set cand = E_START;
  - clear found, timeout and e_out;
  - set busy = 1;
  - go to CHECKRANGE.
- CHECKRANGE:
  - if cand ≥ latched phi, go to FINISH with found = 0. This also covers phi < 3, which fails in 2 cycles.
  - otherwise set gcd_a = cand, gcd_flag = 0, and go to ARM.
- ARM: gcd_flag = 0 for exactly one cycle so the GCD clears. Then set gcd_flag = 1, reset the cycle counter, and go to RUN.
- RUN: gcd_flag stays 1 and operands stay stable. The cycle counter increments each cycle.
  - gcd_complete = 1: capture gcd_result, go to EVAL.
  - counter reaches TIMEOUT - 1 without complete: timeout = 1, found = 0, go to FINISH.
  - complete and the timeout limit in the same cycle: complete wins.
- EVAL: drop gcd_flag.
  - result = 1: e_out = cand, found = 1, go to FINISH.
  - result = 0 (illegal; only possible with a 0 operand): treat as not coprime.
  - otherwise: cand = cand + 2, computed in WIDTH+1 bits. If bit WIDTH is set (wrap), go to FINISH with found = 0. Else go to CHECKRANGE.
- FINISH: done = 1 for one cycle, busy = 0, gcd_flag = 0, back to IDLE. found, timeout and e_out hold until the next accepted start.
- A start that coincides with the done cycle is ignored. A new start is accepted from IDLE on the following cycle.
- Latency per candidate is 3 cycles plus the GCD run time (CHECKRANGE, ARM, EVAL).
- The phi input may change while busy without effect.

Decomposition:
- Shared package rsa_pkg holds:
  - the WIDTH default (12);
  - the state enum IDLE / CHECKRANGE / ARM / RUN / EVAL / FINISH;
  - the E_START constant.
- No sub-module is required. The timeout counter stays inline.
- The GCD unit is instantiated beside this block at the top level, not inside it.

Test Plan:
- phi = 60 with the real GCD → candidates 3, 5, 7 are tried; done with found = 1, e_out = 7, timeout = 0. gcd_flag shows exactly 3 low-high cycles.
- phi = 3120 (p = 61, q = 53) → found = 1, e_out = 7. busy stays high from the start cycle until the done cycle.
- phi = 3, then phi = 2 → each gives done within 3 cycles of start, found = 0, and gcd_flag never rises.
- Stub GCD that never asserts complete, TIMEOUT = 16, phi = 100 → done exactly once, timeout = 1, found = 0, about 18 cycles after start.
- Assert reset during RUN for phi = 60 → gcd_flag = 0 and busy = 0 on the next edge, no done pulse. A fresh start with phi = 60 then gives e_out = 7.
- Pulse start again while busy and on the done cycle → both are ignored and e_out is unchanged. A start one cycle after done is accepted.
